// File: rtl/vcmd_tx.sv
// vcmd_tx: serialises pixel writes and buffer swaps into the VGA command byte stream.
// Optional X/Y position cache enabled by defining VCMD_TX_POS_CACHE_EN.
module vcmd_tx #(
    parameter int LINE_PIXELS = 160,
    parameter int HALF_PERIOD = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic [11:0] i_pix_x,
    input  logic [11:0] i_pix_y,
    input  logic [23:0] i_pix_data,
    input  logic        i_swap_valid,
    output logic        o_swap_ready,
    output logic [7:0]  o_cmd_out,
    output logic        o_cmd_strobe,
    output logic        o_idle
);

    localparam int CW = (2 * HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF_PERIOD - 1);

    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("vcmd_tx: HALF_PERIOD must be >= 1");
    end
    if (LINE_PIXELS < 1 || LINE_PIXELS > 4096) begin : g_bad_line_pixels
        $error("vcmd_tx: LINE_PIXELS must be in 1..4096");
    end

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETXH = 4'd1,
        S_SETXL = 4'd2,
        S_SETYH = 4'd3,
        S_SETYL = 4'd4,
        S_WRCMD = 4'd5,
        S_WRB0  = 4'd6,
        S_WRB1  = 4'd7,
        S_WRB2  = 4'd8,
        S_SWAP  = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_cmd;
    logic          r_strobe;
    logic [11:0]   r_x;
    logic [11:0]   r_y;
    logic [23:0]   r_data;
    logic          r_need_y;
    logic          w_need_x;
    logic          w_need_y;
    logic          w_slot_end;
    logic [11:0]   w_x_sel;
    logic [11:0]   w_y_sel;
    logic [23:0]   w_data_sel;
    logic [7:0]    w_byte_nxt;

    function automatic logic [7:0] f_slot_byte(input state_t s, input logic [11:0] x,
                                               input logic [11:0] y, input logic [23:0] d);
        case (s)
            S_SETXH: f_slot_byte = {4'h2, x[11:8]};
            S_SETXL: f_slot_byte = x[7:0];
            S_SETYH: f_slot_byte = {4'h3, y[11:8]};
            S_SETYL: f_slot_byte = y[7:0];
            S_WRCMD: f_slot_byte = 8'h41;
            S_WRB0:  f_slot_byte = d[7:0];
            S_WRB1:  f_slot_byte = d[15:8];
            S_WRB2:  f_slot_byte = d[23:16];
            S_SWAP:  f_slot_byte = 8'h01;
            default: f_slot_byte = 8'h00;
        endcase
    endfunction

`ifdef VCMD_TX_POS_CACHE_EN
    logic [11:0] r_cur_x;
    logic [11:0] r_cur_y;
    logic        r_cache_valid;

    // Position the decoder will use for the next Write1P, learned from completed pixels.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur_x       <= 12'd0;
            r_cur_y       <= 12'd0;
            r_cache_valid <= 1'b0;
        end else if (r_state == S_WRB2 && w_slot_end) begin
            r_cur_x       <= r_x + 12'd1;
            r_cur_y       <= r_y;
            r_cache_valid <= ((r_x + 12'd1) != 12'(LINE_PIXELS));
        end else begin
            r_cur_x       <= r_cur_x;
            r_cur_y       <= r_cur_y;
            r_cache_valid <= r_cache_valid;
        end
    end

    assign w_need_x = !(r_cache_valid && (i_pix_x == r_cur_x));
    assign w_need_y = !(r_cache_valid && (i_pix_y == r_cur_y));
`else
    assign w_need_x = 1'b1;
    assign w_need_y = 1'b1;
`endif

    // Next-state and next-byte selection; in IDLE the live inputs feed the first byte.
    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_state_nxt = r_state;
        w_x_sel     = r_x;
        w_y_sel     = r_y;
        w_data_sel  = r_data;
        if (r_state == S_IDLE) begin
            w_x_sel    = i_pix_x;
            w_y_sel    = i_pix_y;
            w_data_sel = i_pix_data;
        end else begin
            w_x_sel    = r_x;
        end
        case (r_state)
            S_IDLE: begin
                if (i_pix_valid) begin
                    w_state_nxt = w_need_x ? S_SETXH : (w_need_y ? S_SETYH : S_WRCMD);
                end else if (i_swap_valid) begin
                    w_state_nxt = S_SWAP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETXH: w_state_nxt = w_slot_end ? S_SETXL : r_state;
            S_SETXL: w_state_nxt = w_slot_end ? (r_need_y ? S_SETYH : S_WRCMD) : r_state;
            S_SETYH: w_state_nxt = w_slot_end ? S_SETYL : r_state;
            S_SETYL: w_state_nxt = w_slot_end ? S_WRCMD : r_state;
            S_WRCMD: w_state_nxt = w_slot_end ? S_WRB0 : r_state;
            S_WRB0:  w_state_nxt = w_slot_end ? S_WRB1 : r_state;
            S_WRB1:  w_state_nxt = w_slot_end ? S_WRB2 : r_state;
            S_WRB2:  w_state_nxt = w_slot_end ? S_IDLE : r_state;
            S_SWAP:  w_state_nxt = w_slot_end ? S_IDLE : r_state;
            default: w_state_nxt = S_IDLE;
        endcase
        w_byte_nxt = f_slot_byte(w_state_nxt, w_x_sel, w_y_sel, w_data_sel);
    end

    // State, slot timing and captured request registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cmd    <= 8'h00;
            r_strobe <= 1'b0;
            r_x      <= 12'd0;
            r_y      <= 12'd0;
            r_data   <= 24'd0;
            r_need_y <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_cnt    <= '0;
                r_strobe <= 1'b0;
                if (w_state_nxt != S_IDLE) begin
                    r_cmd    <= w_byte_nxt;
                    r_x      <= i_pix_x;
                    r_y      <= i_pix_y;
                    r_data   <= i_pix_data;
                    r_need_y <= w_need_y;
                end
            end else if (w_slot_end) begin
                r_cnt    <= '0;
                r_strobe <= 1'b0;
                if (w_state_nxt != S_IDLE) begin
                    r_cmd <= w_byte_nxt;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CNT_MID) begin
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    // Reset forces the pins quiet immediately, even mid-byte.
    assign o_pix_ready  = (r_state == S_IDLE) && !i_reset;
    assign o_swap_ready = (r_state == S_IDLE) && !i_reset;
    assign o_idle       = (r_state == S_IDLE) || i_reset;
    assign o_cmd_out    = i_reset ? 8'h00 : r_cmd;
    assign o_cmd_strobe = r_strobe && !i_reset;

endmodule

// File: tb/tb_vcmd_tx.sv
// Directed testbench for vcmd_tx; expectations follow VCMD_TX_POS_CACHE_EN when defined.
module tb_vcmd_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [11:0] pix_x = 12'd0;
    logic [11:0] pix_y = 12'd0;
    logic [23:0] pix_data = 24'd0;
    logic        swap_valid = 1'b0;
    logic        swap_ready;
    logic [7:0]  cmd_out;
    logic        cmd_strobe;
    logic        idle;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stable_err = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  prev_cmd = 8'h00;
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    int          lat;

    vcmd_tx #(.LINE_PIXELS(160), .HALF_PERIOD(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
        .i_pix_x(pix_x), .i_pix_y(pix_y), .i_pix_data(pix_data),
        .i_swap_valid(swap_valid), .o_swap_ready(swap_ready),
        .o_cmd_out(cmd_out), .o_cmd_strobe(cmd_strobe), .o_idle(idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte capture on strobe rise and CmdOut stability while strobe is high.
    always @(negedge clk) begin
        if (cmd_strobe && !prev_strobe) cap_q.push_back(cmd_out);
        if (cmd_strobe && prev_strobe && (cmd_out != prev_cmd)) stable_err <= stable_err + 1;
        prev_strobe <= cmd_strobe;
        prev_cmd    <= cmd_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < cap_q.size()) ? {24'd0, cap_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_pixel(input logic [11:0] x, input logic [11:0] y,
                              input logic [23:0] d, output int l);
        int n;
        int acc;
        cap_q.delete();
        @(negedge clk);
        pix_x = x; pix_y = y; pix_data = d; pix_valid = 1'b1;
        wait_ready(n);
        acc = cyc;
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_x = 12'hFFF; pix_y = 12'hFFF; pix_data = 24'hDEADBE;
        l = -1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (pix_ready) begin
                l = cyc - acc;
                break;
            end
            n++;
        end
    endtask

    initial begin
        int n;
        int acc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd", {24'd0, cmd_out}, 32'h00);
        check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_swap_ready", {31'd0, swap_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, pix_ready}, 32'd1);

        // 1: basic pixel
        send_pixel(12'd5, 12'd7, 24'h332211, lat);
        exp_q = '{8'h20, 8'h05, 8'h30, 8'h07, 8'h41, 8'h11, 8'h22, 8'h33};
        check_stream("t1");
        check("t1_lat", lat, 32'd33);

        // 2: consecutive pixels on one line
        send_pixel(12'd6, 12'd7, 24'h665544, lat);
`ifdef VCMD_TX_POS_CACHE_EN
        exp_q = '{8'h41, 8'h44, 8'h55, 8'h66};
        check_stream("t2a");
        check("t2a_lat", lat, 32'd17);
`else
        exp_q = '{8'h20, 8'h06, 8'h30, 8'h07, 8'h41, 8'h44, 8'h55, 8'h66};
        check_stream("t2a");
        check("t2a_lat", lat, 32'd33);
`endif
        send_pixel(12'd9, 12'd7, 24'h998877, lat);
`ifdef VCMD_TX_POS_CACHE_EN
        exp_q = '{8'h20, 8'h09, 8'h41, 8'h77, 8'h88, 8'h99};
        check_stream("t2b");
        check("t2b_lat", lat, 32'd25);
`else
        exp_q = '{8'h20, 8'h09, 8'h30, 8'h07, 8'h41, 8'h77, 8'h88, 8'h99};
        check_stream("t2b");
        check("t2b_lat", lat, 32'd33);
`endif

        // 3: line end invalidates the cache
        send_pixel(12'd159, 12'd7, 24'hAABBCC, lat);
`ifdef VCMD_TX_POS_CACHE_EN
        exp_q = '{8'h20, 8'h9F, 8'h41, 8'hCC, 8'hBB, 8'hAA};
`else
        exp_q = '{8'h20, 8'h9F, 8'h30, 8'h07, 8'h41, 8'hCC, 8'hBB, 8'hAA};
`endif
        check_stream("t3a");
        send_pixel(12'd160, 12'd7, 24'h010203, lat);
        exp_q = '{8'h20, 8'hA0, 8'h30, 8'h07, 8'h41, 8'h03, 8'h02, 8'h01};
        check_stream("t3b");
        check("t3b_lat", lat, 32'd33);

        // 4: pixel and swap together, pixel wins
        cap_q.delete();
        @(negedge clk);
        pix_x = 12'h010; pix_y = 12'h020; pix_data = 24'h123456;
        pix_valid = 1'b1; swap_valid = 1'b1;
        wait_ready(n);
        acc = cyc;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(negedge clk);
        check("t4_swap_busy", {31'd0, swap_ready}, 32'd0);
        n = 0;
        while (!swap_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_swap_ready_at", cyc - acc, 32'd33);
        acc = cyc;
        @(posedge clk);
        #1;
        swap_valid = 1'b0;
        @(negedge clk);
        wait_ready(n);
        check("t4_swap_lat", cyc - acc, 32'd5);
        exp_q = '{8'h20, 8'h10, 8'h30, 8'h20, 8'h41, 8'h56, 8'h34, 8'h12, 8'h01};
        check_stream("t4");

        // 5: high X bits and strobe-high stability
        send_pixel(12'hABC, 12'h020, 24'h0A0B0C, lat);
`ifdef VCMD_TX_POS_CACHE_EN
        exp_q = '{8'h2A, 8'hBC, 8'h41, 8'h0C, 8'h0B, 8'h0A};
`else
        exp_q = '{8'h2A, 8'hBC, 8'h30, 8'h20, 8'h41, 8'h0C, 8'h0B, 8'h0A};
`endif
        check_stream("t5");
        check("t5_stable", stable_err, 32'd0);

        // 6: reset during the WRB1 strobe-low phase
        cap_q.delete();
        @(negedge clk);
        pix_x = 12'h050; pix_y = 12'h060; pix_data = 24'h111111; pix_valid = 1'b1;
        wait_ready(n);
        acc = cyc;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        n = 0;
        while (cyc != acc + 25 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_pre_bytes", cap_q.size(), 32'd6);
        check("t6_pre_strobe", {31'd0, cmd_strobe}, 32'd0);
        reset = 1'b1;
        #1;
        check("t6_rst_cmd", {24'd0, cmd_out}, 32'h00);
        check("t6_rst_idle", {31'd0, idle}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("t6_rst_strobe", {31'd0, cmd_strobe}, 32'd0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_rise", cap_q.size(), 32'd6);
        check("t6_idle_after", {31'd0, idle}, 32'd1);
        send_pixel(12'hABD, 12'h020, 24'h445566, lat);
        exp_q = '{8'h2A, 8'hBD, 8'h30, 8'h20, 8'h41, 8'h66, 8'h55, 8'h44};
        check_stream("t6_next");
        check("t6_next_lat", lat, 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
